// File: rtl/count_mon_pkg.sv
// Shared types and default sizing for the counter sequence monitor.
package count_mon_pkg;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_WRAP_W   = 8;
  localparam int unsigned DEF_LOCK_CNT = 2;
  localparam int unsigned DEF_ERR_W    = 8;
  localparam int unsigned GOOD_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/count_seq_monitor_if.sv
// Counter sample inputs and monitor status outputs as one bundle.
interface count_seq_monitor_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
);
  logic                    en;
  logic [WIDTH-1:0]        q_in;
  logic [WIDTH-1:0]        qb_in;
  logic                    tc;
  logic                    err;
  logic                    locked;
  logic [WRAP_W-1:0]       wrap_cnt;
  logic [WRAP_W+WIDTH-1:0] ext_count;
  logic [ERR_W-1:0]        err_cnt;

  modport master (output en, q_in, qb_in,
                  input  tc, err, locked, wrap_cnt, ext_count, err_cnt);
  modport slave  (input  en, q_in, qb_in,
                  output tc, err, locked, wrap_cnt, ext_count, err_cnt);
endinterface

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = W'(cnt_q + W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/count_seq_monitor.sv
// Checks an up-counter's q/qb stream, extends it with a wrap count and flags errors.
// Complement checking of qb_in is enabled by defining CSM_QB_CHECK_EN.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned WRAP_W   = DEF_WRAP_W,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               rst,
  count_seq_monitor_if.slave bus
);
  mon_state_e         state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;
  logic               tc_q, tc_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic [ERR_W-1:0]   err_cnt;

  logic inc_c, cpl_ok_c, good_s_c, restart_c, q_zero_c;

  assign inc_c     = (bus.q_in == WIDTH'(prev_q + WIDTH'(1)));
  assign q_zero_c  = (bus.q_in == '0);
  assign restart_c = q_zero_c && (prev_q != {WIDTH{1'b1}});
`ifdef CSM_QB_CHECK_EN
  assign cpl_ok_c  = (bus.qb_in == ~bus.q_in);
`else
  logic qb_unused;
  assign qb_unused = ^bus.qb_in;
  assign cpl_ok_c  = 1'b1;
`endif
  assign good_s_c  = inc_c && cpl_ok_c;

  // Next-state: every enabled sample advances prev; the FSM decides the pulses.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    wrap_d  = wrap_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.en) begin
      prev_d = bus.q_in;
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          good_d  = '0;
        end
        SYNC: begin
          if (good_s_c) begin
            good_d = GOOD_W'(good_q + GOOD_W'(1));
            if (good_d >= GOOD_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              good_d  = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (good_s_c) begin
            if (q_zero_c) begin
              tc_d   = 1'b1;
              wrap_d = WRAP_W'(wrap_q + WRAP_W'(1));
            end
          end else if (restart_c) begin
            // Upstream counter reset back to 0: resync quietly.
            state_d = SYNC;
            good_d  = '0;
            wrap_d  = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
        ERROR: begin
          state_d = SYNC;
          good_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      wrap_q   <= '0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      wrap_q   <= wrap_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_d),
    .cnt_o (err_cnt)
  );

  assign bus.tc        = tc_q;
  assign bus.err       = err_q;
  assign bus.locked    = locked_q;
  assign bus.wrap_cnt  = wrap_q;
  assign bus.ext_count = {wrap_q, prev_q};
  assign bus.err_cnt   = err_cnt;
endmodule
